// File: rtl/sfp_pkg.sv
// Shared encodings for the SFP TX arbiter: grant owners, FSM states, default width.
package sfp_pkg;

  localparam int unsigned SFP_DATA_W = 64;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_CMD   = 2'd1,
    GNT_LOCAL = 2'd2,
    GNT_PEER  = 2'd3
  } grant_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/sfp_rr_pick.sv
// Two-way round-robin pick between local and peer; the pointer only matters on a tie.
module sfp_rr_pick (
  input  logic ptr_peer_i,
  input  logic local_valid_i,
  input  logic peer_valid_i,
  output logic pick_peer_o,
  output logic any_o
);

  always_comb begin
    any_o = local_valid_i | peer_valid_i;
    if (local_valid_i && peer_valid_i) begin
      pick_peer_o = ptr_peer_i;
    end else begin
      pick_peer_o = peer_valid_i;
    end
  end

endmodule

// File: rtl/sfp_tx_arbiter.sv
// SFP TX link arbiter: strict-priority cmd, bounded round-robin local/peer, flush on link down.
// Optional per-source beat counters are built when SFP_TX_STATS_EN is defined.
module sfp_tx_arbiter
  import sfp_pkg::*;
#(
  parameter int unsigned DATA_W    = SFP_DATA_W,
  parameter int unsigned MAX_BURST = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_channel_up,
  input  logic [DATA_W-1:0] s_cmd_tdata,
  input  logic              s_cmd_tvalid,
  output logic              s_cmd_tready,
  input  logic [DATA_W-1:0] s_local_tdata,
  input  logic              s_local_tvalid,
  output logic              s_local_tready,
  input  logic [DATA_W-1:0] s_peer_tdata,
  input  logic              s_peer_tvalid,
  output logic              s_peer_tready,
  output logic [DATA_W-1:0] m_tx_sfp_tdata,
  output logic              m_tx_sfp_tvalid,
  input  logic              m_tx_sfp_tready,
  output logic [1:0]        o_grant,
  output logic [1:0]        o_state,
`ifdef SFP_TX_STATS_EN
  output logic [31:0]       o_cmd_beats,
  output logic [31:0]       o_local_beats,
  output logic [31:0]       o_peer_beats,
`endif
  output logic [15:0]       o_drop_cnt
);

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  logic [7:0]  burst_q, burst_d;
  logic        rr_peer_q, rr_peer_d;
  logic [15:0] drop_q, drop_d;

  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              in_grant;
  logic              beat;
  logic              done;
  logic              pick_peer;
  logic              pick_any;

  sfp_rr_pick u_rr_pick (
    .ptr_peer_i    (rr_peer_q),
    .local_valid_i (s_local_tvalid),
    .peer_valid_i  (s_peer_tvalid),
    .pick_peer_o   (pick_peer),
    .any_o         (pick_any)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    unique case (grant_q)
      GNT_CMD:   begin sel_data = s_cmd_tdata;   sel_valid = s_cmd_tvalid;   end
      GNT_LOCAL: begin sel_data = s_local_tdata; sel_valid = s_local_tvalid; end
      GNT_PEER:  begin sel_data = s_peer_tdata;  sel_valid = s_peer_tvalid;  end
      default:   ;
    endcase
    in_grant        = (state_q == ST_GRANT);
    m_tx_sfp_tvalid = in_grant & sel_valid;
    m_tx_sfp_tdata  = in_grant ? sel_data : '0;
    s_cmd_tready    = in_grant && (grant_q == GNT_CMD) && m_tx_sfp_tready;
    s_local_tready  = (in_grant && (grant_q == GNT_LOCAL) && m_tx_sfp_tready)
                      || (state_q == ST_FLUSH);
    s_peer_tready   = (in_grant && (grant_q == GNT_PEER) && m_tx_sfp_tready)
                      || (state_q == ST_FLUSH);
    beat            = m_tx_sfp_tvalid & m_tx_sfp_tready;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    rr_peer_d = rr_peer_q;
    drop_d    = drop_q;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!i_channel_up) begin
          state_d = ST_FLUSH;
        end else if (s_cmd_tvalid) begin
          grant_d = GNT_CMD;
          state_d = ST_GRANT;
        end else if (pick_any) begin
          grant_d = pick_peer ? GNT_PEER : GNT_LOCAL;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (grant_q == GNT_CMD) begin
          done = beat || !sel_valid;
        end else begin
          done = (beat && (burst_q == 8'(MAX_BURST - 1))) || !sel_valid;
        end
        // Link down: only a beat already on the bus may still complete.
        if (!i_channel_up) begin
          done = beat || !sel_valid;
        end
        if (done) begin
          state_d = i_channel_up ? ST_IDLE : ST_FLUSH;
          grant_d = GNT_NONE;
          burst_d = '0;
          if (grant_q != GNT_CMD) begin
            rr_peer_d = (grant_q == GNT_LOCAL);
          end
        end else if (beat) begin
          burst_d = burst_q + 8'd1;
        end
      end
      ST_FLUSH: begin
        drop_d = sat_add16(drop_q, {1'b0, s_local_tvalid} + {1'b0, s_peer_tvalid});
        if (i_channel_up) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_NONE;
      burst_q   <= '0;
      rr_peer_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      burst_q   <= burst_d;
      rr_peer_q <= rr_peer_d;
      drop_q    <= drop_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_state    = state_q;
  assign o_drop_cnt = drop_q;

`ifdef SFP_TX_STATS_EN
  logic [31:0] cmd_beats_q, local_beats_q, peer_beats_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cmd_beats_q   <= '0;
      local_beats_q <= '0;
      peer_beats_q  <= '0;
    end else if (beat) begin
      if (grant_q == GNT_CMD)   cmd_beats_q   <= cmd_beats_q + 32'd1;
      if (grant_q == GNT_LOCAL) local_beats_q <= local_beats_q + 32'd1;
      if (grant_q == GNT_PEER)  peer_beats_q  <= peer_beats_q + 32'd1;
    end
  end

  assign o_cmd_beats   = cmd_beats_q;
  assign o_local_beats = local_beats_q;
  assign o_peer_beats  = peer_beats_q;
`endif

endmodule

// File: tb/tb_sfp_tx_arbiter.sv
// Directed self-checking bench for sfp_tx_arbiter with small FIFO models per source.
module tb_sfp_tx_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_channel_up;
  logic [63:0] s_cmd_tdata, s_local_tdata, s_peer_tdata;
  logic        s_cmd_tvalid, s_local_tvalid, s_peer_tvalid;
  logic        s_cmd_tready, s_local_tready, s_peer_tready;
  logic [63:0] m_tx_sfp_tdata;
  logic        m_tx_sfp_tvalid;
  logic        m_tx_sfp_tready;
  logic [1:0]  o_grant, o_state;
  logic [15:0] o_drop_cnt;

  sfp_tx_arbiter #(.DATA_W(64), .MAX_BURST(9)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_channel_up    (i_channel_up),
    .s_cmd_tdata     (s_cmd_tdata),
    .s_cmd_tvalid    (s_cmd_tvalid),
    .s_cmd_tready    (s_cmd_tready),
    .s_local_tdata   (s_local_tdata),
    .s_local_tvalid  (s_local_tvalid),
    .s_local_tready  (s_local_tready),
    .s_peer_tdata    (s_peer_tdata),
    .s_peer_tvalid   (s_peer_tvalid),
    .s_peer_tready   (s_peer_tready),
    .m_tx_sfp_tdata  (m_tx_sfp_tdata),
    .m_tx_sfp_tvalid (m_tx_sfp_tvalid),
    .m_tx_sfp_tready (m_tx_sfp_tready),
    .o_grant         (o_grant),
    .o_state         (o_state),
    .o_drop_cnt      (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  int loc_left, peer_left, loc_idx, peer_idx;
  int loc_hs, peer_hs, cmd_hs;
  logic        cmd_pend;
  logic [63:0] cmd_data;

  logic [63:0] txlog[$];
  int          glog[$];
  int          runs_g[$], runs_len[$];
  int          exp_g[$], exp_len[$];
  int          gap_bad;

  logic [1:0]  snap_grant, snap_state;
  logic        snap_tvalid, snap_cmd_rdy;
  logic [63:0] snap_tdata;
  logic        prev_stall;
  logic [63:0] prev_data;
  int          stab_err, stalls;

  function automatic logic [63:0] ldat(input int i);
    return {8'hA0, 24'h0, 32'(i)};
  endfunction

  function automatic logic [63:0] pdat(input int i);
    return {8'hB0, 24'h0, 32'(i)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s_local_tvalid = (loc_left > 0);
    s_local_tdata  = ldat(loc_idx);
    s_peer_tvalid  = (peer_left > 0);
    s_peer_tdata   = pdat(peer_idx);
    s_cmd_tvalid   = cmd_pend;
    s_cmd_tdata    = cmd_data;
  endtask

  task automatic clear_logs();
    txlog.delete();
    glog.delete();
    loc_hs = 0; peer_hs = 0; cmd_hs = 0;
    prev_stall = 1'b0; stab_err = 0; stalls = 0;
  endtask

  // One clock: sample at negedge, advance the source models just after posedge.
  task automatic cycle();
    logic hl, hp, hc;
    @(negedge i_clk);
    hl = s_local_tvalid && s_local_tready;
    hp = s_peer_tvalid && s_peer_tready;
    hc = s_cmd_tvalid && s_cmd_tready;
    snap_grant = o_grant; snap_state = o_state; snap_tvalid = m_tx_sfp_tvalid;
    snap_tdata = m_tx_sfp_tdata; snap_cmd_rdy = s_cmd_tready;
    glog.push_back(int'(o_grant));
    if (m_tx_sfp_tvalid && m_tx_sfp_tready) txlog.push_back(m_tx_sfp_tdata);
    if (prev_stall && m_tx_sfp_tvalid && (m_tx_sfp_tdata !== prev_data)) stab_err++;
    prev_stall = m_tx_sfp_tvalid && !m_tx_sfp_tready;
    if (prev_stall) stalls++;
    prev_data = m_tx_sfp_tdata;
    @(posedge i_clk);
    #1;
    if (hl) begin loc_left--; loc_idx++; loc_hs++; end
    if (hp) begin peer_left--; peer_idx++; peer_hs++; end
    if (hc) begin cmd_pend = 1'b0; cmd_hs++; end
    drive();
  endtask

  task automatic get_runs();
    int cur, len, zeros;
    runs_g.delete(); runs_len.delete();
    gap_bad = 0; cur = 0; len = 0; zeros = 0;
    foreach (glog[i]) begin
      if (glog[i] == cur && glog[i] != 0) begin
        len++;
      end else begin
        if (cur > 0) begin runs_g.push_back(cur); runs_len.push_back(len); end
        if (glog[i] != 0) begin
          if (runs_g.size() > 0 && zeros != 1) gap_bad++;
          zeros = 0; cur = glog[i]; len = 1;
        end else begin
          zeros++; cur = 0;
        end
      end
    end
    if (cur > 0) begin runs_g.push_back(cur); runs_len.push_back(len); end
  endtask

  task automatic check_runs(input string tag, input bit prefix_only);
    int g, l;
    get_runs();
    if (!prefix_only) check({tag, "_nruns"}, 64'(runs_g.size()), 64'(exp_g.size()));
    for (int i = 0; i < exp_g.size(); i++) begin
      g = (i < runs_g.size()) ? runs_g[i] : -1;
      l = (i < runs_len.size()) ? runs_len[i] : -1;
      check($sformatf("%s_run%0d_owner", tag, i), 64'(g), 64'(exp_g[i]));
      check($sformatf("%s_run%0d_len", tag, i), 64'(l), 64'(exp_len[i]));
    end
    check({tag, "_gaps"}, 64'(gap_bad), 64'd0);
  endtask

  initial begin
    logic [63:0] expq[$];
    int          derr;
    bit          armed;

    i_rst = 1'b0; i_channel_up = 1'b1; m_tx_sfp_tready = 1'b1;
    loc_left = 0; peer_left = 0; loc_idx = 0; peer_idx = 0;
    cmd_pend = 1'b0; cmd_data = '0;
    drive(); clear_logs();

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_grant", 64'(o_grant), 64'd0);
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_tvalid", 64'(m_tx_sfp_tvalid), 64'd0);
    check("rst_tdata", m_tx_sfp_tdata, 64'd0);
    check("rst_treadys", 64'({s_cmd_tready, s_local_tready, s_peer_tready}), 64'd0);
    check("rst_drop", 64'(o_drop_cnt), 64'd0);
    i_rst = 1'b1;

    // 1: single cmd beat
    @(posedge i_clk); #1;
    cmd_pend = 1'b1; cmd_data = 64'h1000_0010_0000_0064; drive();
    cycle();
    check("t1_latency_grant", 64'(snap_grant), 64'd0);
    check("t1_latency_rdy", 64'(snap_cmd_rdy), 64'd0);
    cycle();
    check("t1_grant", 64'(snap_grant), 64'd1);
    check("t1_tvalid", 64'(snap_tvalid), 64'd1);
    check("t1_tdata", snap_tdata, 64'h1000_0010_0000_0064);
    check("t1_cmd_rdy", 64'(snap_cmd_rdy), 64'd1);
    cycle();
    check("t1_release_grant", 64'(snap_grant), 64'd0);
    check("t1_release_tdata", snap_tdata, 64'd0);
    check("t1_cmd_hs", 64'(cmd_hs), 64'd1);

    // 2: local/peer 20 beats each, bursts of 9
    clear_logs();
    loc_left = 20; peer_left = 20; loc_idx = 0; peer_idx = 0; drive();
    for (int k = 0; k < 60; k++) cycle();
    exp_g = '{2, 3, 2, 3, 2, 3};
    exp_len = '{9, 9, 9, 9, 3, 3};
    check_runs("t2", 1'b0);
    expq.delete();
    for (int i = 0; i < 9; i++) expq.push_back(ldat(i));
    for (int i = 0; i < 9; i++) expq.push_back(pdat(i));
    for (int i = 9; i < 18; i++) expq.push_back(ldat(i));
    for (int i = 9; i < 18; i++) expq.push_back(pdat(i));
    expq.push_back(ldat(18)); expq.push_back(ldat(19));
    expq.push_back(pdat(18)); expq.push_back(pdat(19));
    check("t2_nbeats", 64'(txlog.size()), 64'd40);
    derr = 0;
    foreach (expq[i]) if (i >= txlog.size() || txlog[i] !== expq[i]) derr++;
    check("t2_beat_order", 64'(derr), 64'd0);

    // 3: cmd during the 4th local beat waits for the burst to end, then beats peer
    clear_logs();
    loc_left = 9; peer_left = 5; loc_idx = 0; peer_idx = 0; drive();
    armed = 1'b1;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (armed && loc_hs == 3) begin
        cmd_pend = 1'b1; cmd_data = 64'hC3C3_0000_0000_0003; drive(); armed = 1'b0;
      end
    end
    exp_g = '{2, 1, 3};
    exp_len = '{9, 1, 6};
    check_runs("t3", 1'b0);
    check("t3_nbeats", 64'(txlog.size()), 64'd15);
    check("t3_last_local", (txlog.size() > 8) ? txlog[8] : 64'd0, ldat(8));
    check("t3_cmd_beat", (txlog.size() > 9) ? txlog[9] : 64'd0, 64'hC3C3_0000_0000_0003);
    check("t3_first_peer", (txlog.size() > 10) ? txlog[10] : 64'd0, pdat(0));

    // 4: tready toggling 1010 during a peer burst
    clear_logs();
    loc_left = 0; peer_left = 9; loc_idx = 0; peer_idx = 0; drive();
    for (int k = 0; k < 40; k++) begin
      m_tx_sfp_tready = (k % 2 == 0);
      cycle();
    end
    m_tx_sfp_tready = 1'b1;
    check("t4_peer_hs", 64'(peer_hs), 64'd9);
    check("t4_nbeats", 64'(txlog.size()), 64'd9);
    derr = 0;
    for (int i = 0; i < 9; i++) if (i >= txlog.size() || txlog[i] !== pdat(i)) derr++;
    check("t4_beat_order", 64'(derr), 64'd0);
    check("t4_stable_while_stalled", 64'(stab_err), 64'd0);
    check("t4_stall_cycles", 64'(stalls), 64'd9);

    // 5: link drop mid local burst, flush, then held cmd goes out
    clear_logs();
    loc_left = 8; peer_left = 3; loc_idx = 0; peer_idx = 0; drive();
    for (int k = 0; k < 20; k++) if (loc_hs < 2) cycle();
    check("t5_reach_burst", 64'(loc_hs), 64'd2);
    i_channel_up = 1'b0;
    cmd_pend = 1'b1; cmd_data = 64'hC5C5_0000_0000_0005; drive();
    cycle();
    derr = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (snap_state !== 2'd2 || snap_tvalid !== 1'b0 || snap_cmd_rdy !== 1'b0) derr++;
    end
    check("t5_flush_outputs", 64'(derr), 64'd0);
    check("t5_drop_cnt", 64'(o_drop_cnt), 64'd8);
    check("t5_queues_drained", 64'(loc_left + peer_left), 64'd0);
    check("t5_cmd_held", 64'(cmd_pend), 64'd1);
    check("t5_tx_beats_before", 64'(txlog.size()), 64'd3);
    i_channel_up = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    check("t5_cmd_sent", 64'(cmd_pend), 64'd0);
    check("t5_cmd_data", (txlog.size() > 3) ? txlog[3] : 64'd0, 64'hC5C5_0000_0000_0005);
    check("t5_state_idle", 64'(o_state), 64'd0);
    check("t5_drop_kept", 64'(o_drop_cnt), 64'd8);

    // 6: async reset mid burst; pointer returns to local
    clear_logs();
    loc_left = 20; peer_left = 0; loc_idx = 0; peer_idx = 0; drive();
    for (int k = 0; k < 4; k++) cycle();
    check("t6_in_burst", 64'(o_grant), 64'd2);
    i_rst = 1'b0;
    #1;
    check("t6_rst_grant", 64'(o_grant), 64'd0);
    check("t6_rst_state", 64'(o_state), 64'd0);
    check("t6_rst_tvalid", 64'(m_tx_sfp_tvalid), 64'd0);
    check("t6_rst_tdata", m_tx_sfp_tdata, 64'd0);
    check("t6_rst_local_rdy", 64'(s_local_tready), 64'd0);
    check("t6_rst_drop", 64'(o_drop_cnt), 64'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    clear_logs();
    loc_left = 10; peer_left = 10; loc_idx = 0; peer_idx = 0; drive();
    for (int k = 0; k < 25; k++) cycle();
    exp_g = '{2, 3};
    exp_len = '{9, 9};
    check_runs("t6", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sfp_tx_arbiter.md
Name: sfp_tx_arbiter

Overview:
Shares the single 64-bit SFP TX AXI-Stream link among three requesters:
- master command source (cmd);
- local telemetry FIFO (local);
- peer-forwarding FIFO (peer).

Grant policy: strict priority for cmd; round-robin between local and peer with bounded bursts. While the Aurora channel is down, local and peer traffic is flushed. The block sits between the SFP command/telemetry producers and the Aurora TX user interface.

Parameters:
- DATA_W, 64, stream data width.
- MAX_BURST, 9, maximum beats per local/peer grant before re-arbitration. Range 1..255.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-low.
- i_channel_up  in  1  Aurora channel up.
- s_cmd_tdata  in  DATA_W  command beat.
- s_cmd_tvalid  in  1  command valid.
- s_cmd_tready  out  1  command ready.
- s_local_tdata  in  DATA_W  local FIFO data.
- s_local_tvalid  in  1  local valid.
- s_local_tready  out  1  local ready.
- s_peer_tdata  in  DATA_W  peer FIFO data.
- s_peer_tvalid  in  1  peer valid.
- s_peer_tready  out  1  peer ready.
- m_tx_sfp_tdata  out  DATA_W  to Aurora TX.
- m_tx_sfp_tvalid  out  1  TX valid.
- m_tx_sfp_tready  in  1  TX ready.
- o_grant  out  2  current owner: 0 none, 1 cmd, 2 local, 3 peer.
- o_state  out  2  FSM state, for debug.
- o_drop_cnt  out  16  beats flushed while link down; saturating.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is asynchronous, active-low.
- Reset values:
  - FSM in IDLE; o_grant=0; burst counter 0; round-robin pointer = local.
  - o_drop_cnt=0; m_tx_sfp_tvalid=0; m_tx_sfp_tdata=0.
  - All s_*_tready=0.
  - A reset asserted mid-burst forces these values immediately.
- FSM states: IDLE=0, GRANT=1, FLUSH=2.
- IDLE:
  - If ~i_channel_up, go to FLUSH.
  - Else if s_cmd_tvalid, grant cmd.
  - Else if exactly one of local/peer is valid, grant it.
  - Else if both are valid, grant the one the round-robin pointer names.
  - A grant registers o_grant and moves to GRANT.
  - Arbitration latency: 1 cycle from tvalid to the grant taking effect.
- GRANT datapath (combinational pass-through from the selected source):
  - m_tx_sfp_tdata = selected tdata; m_tx_sfp_tvalid = selected tvalid.
  - Selected tready = m_tx_sfp_tready. Non-selected tready = 0.
  - m_tx_sfp_tdata = 0 whenever no grant is held.
- Beat: selected tvalid & m_tx_sfp_tready. Each beat increments the burst counter.
- Release of a cmd grant: on the first beat. Command is single-beat.
- Release of a local/peer grant, whichever comes first:
  - on a beat where burst counter == MAX_BURST-1;
  - on any cycle the selected tvalid is low.
- On release:
  - Return to IDLE, clear the counter, set o_grant=0.
  - If local/peer released, point round-robin at the other source.
  - There is always at least one idle cycle between grants.
- Link loss:
  - If i_channel_up falls while in GRANT, finish only a beat already presented and stalled (tvalid high). Then go to FLUSH; do not release to IDLE.
- FLUSH:
  - m_tx_sfp_tvalid=0. s_local_tready=1 and s_peer_tready=1; those beats are discarded.
  - s_cmd_tready=0: commands are held, never dropped.
  - o_drop_cnt += (local beat) + (peer beat) per cycle, 0..2, saturating at 16'hFFFF.
  - Return to IDLE on the first cycle i_channel_up=1.
- Simultaneous cmd and local/peer valid in IDLE: cmd wins. The round-robin pointer is unchanged.
- A cmd arriving during a local/peer burst waits for the release. It is not preemptive.

Optional Feature:
- Macro: SFP_TX_STATS_EN.
- When defined, add outputs o_cmd_beats, o_local_beats, o_peer_beats, each 32 bits.
  - Each counts forwarded beats per source and wraps modulo 2^32.
  - All three reset to 0.
- When undefined, these ports and their counters are absent. Core behaviour is identical.

Decomposition:
- Shared package sfp_pkg holds:
  - grant encodings GNT_NONE/CMD/LOCAL/PEER;
  - FSM encodings ST_IDLE/ST_GRANT/ST_FLUSH;
  - DATA_W default.
- One natural sub-module, sfp_rr_pick: combinational 2-way round-robin selector taking the pointer and two valids, returning a select and an any-valid flag.
- The FSM and datapath stay in the top module.

Test Plan:
1. Link up; cmd valid with tdata 64'h1000_0010_0000_0064; tready=1 -> o_grant=1 next cycle, one beat on TX with that data, cmd tready pulses once, o_grant returns to 0.
2. Local and peer both hold 20 beats; tready=1 -> local 9 beats, peer 9, local 9, peer 9, local 2, peer 2. Exactly one gap cycle between grants.
3. Cmd asserted during the 4th local beat -> local completes all 9 beats, then cmd is granted before peer.
4. m_tx_sfp_tready toggles 1010 during a peer burst -> data is held stable while stalled, no beats are lost or duplicated, and the peer FIFO sees exactly 9 handshakes.
5. i_channel_up drops mid-local-burst with 5 local and 3 peer beats queued -> TX tvalid drops, o_state=2, o_drop_cnt reaches 8, cmd tready stays 0. Link returns -> IDLE, pending cmd is sent.
6. Assert i_rst low mid-burst for 1 cycle -> all outputs are 0 immediately, and arbitration restarts with the pointer at local.
